pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised fetch program-counter unit for the RISC-V core: holds the architectural fetch PC and selects the next PC each cycle from reset vector, trap vector, branch/jump redirect, return-address prediction, stall hold, or sequential increment. Sits at the head of the fetch stage, driving instruction-memory address. Generalises the plain always-enabled PC register with stall, redirect priority, alignment checking and an optional return-address stack (RAS).

## Interface
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INST_BYTES, 4, sequential increment; legal values 2 or 4.
- RAS_DEPTH, 4, RAS entries (power of two, 2..16); unused without RAS.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC (fetch back-pressure).
- trap_valid  in  1  take trap this cycle.
- trap_vector  in  XLEN  trap handler address.
- redirect_valid  in  1  branch/jump resolved, PC must change.
- redirect_target  in  XLEN  resolved target.
- call_valid  in  1  instruction at current pc is a call (push pc+INST_BYTES).
- ret_valid  in  1  instruction at current pc is a return (pop prediction).
- pc  out  XLEN  registered fetch PC.
- pc_next  out  XLEN  combinational next PC.
- misalign_err  out  1  registered one-cycle pulse: last loaded trap/redirect target was misaligned.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries (constant 0 without RAS).

## Operation
- Next-PC priority, highest first: trap_valid → trap_vector; redirect_valid → redirect_target; ret_valid & RAS non-empty & !stall → RAS top; stall → pc; else pc + INST_BYTES.
- trap and redirect override stall.
- Alignment: target bits below log2(INST_BYTES) nonzero → those bits cleared in loaded PC, misalign_err = 1 next cycle; else 0.
- Sequential add wraps modulo 2^XLEN; no carry flag.
- RAS (when compiled in), updated only when !stall and no trap/redirect:
  - call only: push pc+INST_BYTES; full → overwrite oldest, count stays RAS_DEPTH.
  - ret only: pop; empty → no pop, PC goes sequential.
  - call & ret same cycle: replace top with pc+INST_BYTES, count unchanged (empty → push); pc_next = old top (empty → sequential).
- trap_valid clears RAS (count 0). redirect_valid leaves RAS unchanged.
- call/ret while stalled: ignored.

## Timing
- Reset (async assert): pc = RESET_VECTOR, misalign_err = 0, ras_count = 0, RAS pointer = 0, entries don't-care.
- First edge after rst deasserts: pc ← pc_next (RESET_VECTOR+INST_BYTES absent other inputs).
- Latency: any selected source visible on pc one cycle later; pc_next same cycle, combinational.
- misalign_err asserted exactly in cycle pc shows the corrected target.
- rst mid-operation discards pending redirect/trap and RAS contents.

## Configuration
- PC_RAS_EN defined: RAS storage, pointer and count built; ret prediction active.
- Not defined: no RAS logic; call_valid/ret_valid ignored; ras_count tied 0; priority reduces to trap, redirect, stall, sequential.

## Structure
- Shared package pc_pkg: next-PC source enum (PC_SRC_RESET, PC_SRC_TRAP, PC_SRC_REDIRECT, PC_SRC_RAS, PC_SRC_HOLD, PC_SRC_SEQ), default RESET_VECTOR and INST_BYTES constants.
- One sub-module: pc_ras (circular stack with push/pop/replace/clear, top, count), instantiated under PC_RAS_EN.
- PC register and next-PC mux stay in pc_unit.

## Test plan
- Reset then 3 idle cycles, RESET_VECTOR=0 → pc 0, 4, 8, 12; rst mid-run → pc 0 immediately, no clock needed.
- stall=1 two cycles at pc=0x10, redirect_valid=1 target 0x80 during stall → pc holds 0x10, then 0x80 next cycle.
- trap_valid & redirect_valid same cycle, vector 0x100, target 0x200 → pc=0x100; redirect target 0x203 → pc 0x200, misalign_err=1 one cycle.
- PC_RAS_EN, call at pc 0x40, redirect to 0x400, ret at 0x400 → pc 0x44, ras_count 1→0; ret with empty RAS → sequential 0x404.
- PC_RAS_EN, RAS_DEPTH=4, five calls from 0x0,0x10,0x20,0x30,0x40 → count 4; four rets → 0x44,0x34,0x24,0x14; fifth ret sequential.
- pc=0xFFFF_FFFC idle → wraps to 0x0; trap_valid with count 3 → ras_count 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC unit: next-PC source encoding and default parameters.
// Optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SRC_RESET    = 3'd0,
    PC_SRC_TRAP     = 3'd1,
    PC_SRC_REDIRECT = 3'd2,
    PC_SRC_RAS      = 3'd3,
    PC_SRC_HOLD     = 3'd4,
    PC_SRC_SEQ      = 3'd5
  } pc_src_e;

  localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_DEF_INST_BYTES   = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, replace-top (push+pop) and clear; full push overwrites oldest.
// Single-cycle update; o_top/o_count reflect registered state.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [XLEN-1:0]            i_dat,
  output logic [XLEN-1:0]            o_top,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   w_top_idx;
  logic            w_nonempty;
  logic            w_replace;

  assign w_top_idx  = r_ptr - AW'(1);
  assign w_nonempty = (r_count != '0);
  assign w_replace  = i_push && i_pop && w_nonempty;
  assign o_top      = r_mem[w_top_idx];
  assign o_count    = r_count;

  // r_ptr is the next free slot; wrapping onto the oldest entry when full is the overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_replace) begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
    end else if (i_push) begin
      r_ptr <= r_ptr + AW'(1);
      if (r_count != CW'(DEPTH)) r_count <= r_count + CW'(1);
    end else if (i_pop && w_nonempty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_clear) begin
      if (w_replace)   r_mem[w_top_idx] <= i_dat;
      else if (i_push) r_mem[r_ptr]     <= i_dat;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: trap > redirect > RAS > hold > sequential; pc_next combinational, pc one cycle later.
// Stall holds the PC unless trap/redirect overrides; optional return-address stack under PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(PC_DEF_RESET_VECTOR),
  parameter int               INST_BYTES   = PC_DEF_INST_BYTES,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          trap_valid,
  input  logic [XLEN-1:0]               trap_vector,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_target,
  input  logic                          call_valid,
  input  logic                          ret_valid,
  output logic [XLEN-1:0]               pc,
  output logic [XLEN-1:0]               pc_next,
  output logic                          misalign_err,
  output logic [$clog2(RAS_DEPTH):0]    ras_count
);

  localparam int              CW         = $clog2(RAS_DEPTH) + 1;
  localparam logic [XLEN-1:0] LOW_MASK   = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_tgt;
  logic            w_tgt_mis;
  logic [XLEN-1:0] w_ras_top;
  logic [CW-1:0]   w_ras_count;
  logic            w_ras_hit;
  pc_src_e         w_src;

  assign w_seq     = r_pc + XLEN'(INST_BYTES);
  assign w_tgt     = trap_valid ? trap_vector : redirect_target;
  assign w_tgt_mis = (trap_valid || redirect_valid) && ((w_tgt & LOW_MASK) != '0);

`ifdef PC_RAS_EN
  logic w_ras_upd;
  assign w_ras_upd = !stall && !trap_valid && !redirect_valid;
  assign w_ras_hit = ret_valid && !stall && (w_ras_count != '0);

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_clear (trap_valid),
    .i_push  (w_ras_upd && call_valid),
    .i_pop   (w_ras_upd && ret_valid),
    .i_dat   (w_seq),
    .o_top   (w_ras_top),
    .o_count (w_ras_count)
  );
`else
  logic w_unused_ras;
  assign w_unused_ras = call_valid ^ ret_valid;
  assign w_ras_hit    = 1'b0;
  assign w_ras_top    = '0;
  assign w_ras_count  = '0;
`endif

  always_comb begin
    if (rst)                 w_src = PC_SRC_RESET;
    else if (trap_valid)     w_src = PC_SRC_TRAP;
    else if (redirect_valid) w_src = PC_SRC_REDIRECT;
    else if (w_ras_hit)      w_src = PC_SRC_RAS;
    else if (stall)          w_src = PC_SRC_HOLD;
    else                     w_src = PC_SRC_SEQ;
  end

  // Trap and redirect targets are forced onto an instruction boundary.
  always_comb begin
    pc_next = w_seq;
    case (w_src)
      PC_SRC_RESET:    pc_next = RESET_VECTOR;
      PC_SRC_TRAP,
      PC_SRC_REDIRECT: pc_next = w_tgt & ~LOW_MASK;
      PC_SRC_RAS:      pc_next = w_ras_top;
      PC_SRC_HOLD:     pc_next = r_pc;
      default:         pc_next = w_seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VECTOR;
      r_misalign <= 1'b0;
    end else begin
      r_pc       <= pc_next;
      r_misalign <= w_tgt_mis;
    end
  end

  assign pc           = r_pc;
  assign misalign_err = r_misalign;
  assign ras_count    = w_ras_count;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expectations; RAS scenarios apply when PC_RAS_EN is defined.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call_valid;
  logic        ret_valid;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        misalign_err;
  logic [2:0]  ras_count;

  int n_cmp = 0;
  int n_err = 0;

  pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .INST_BYTES(4), .RAS_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call_valid      (call_valid),
    .ret_valid       (ret_valid),
    .pc              (pc),
    .pc_next         (pc_next),
    .misalign_err    (misalign_err),
    .ras_count       (ras_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; trap_valid = 0; redirect_valid = 0; call_valid = 0; ret_valid = 0;
    trap_vector = '0; redirect_target = '0;
  endtask

  task automatic jump(input logic [31:0] tgt);
    redirect_valid = 1; redirect_target = tgt;
    tick();
    redirect_valid = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #2;
    check("reset_pc", pc, 32'h0);
    check("reset_misalign", {31'b0, misalign_err}, 32'h0);
    check("reset_ras_count", {29'b0, ras_count}, 32'h0);
    tick();
    rst = 0;
    #1;
    check("pc_next_after_reset", pc_next, 32'h4);
    tick(); check("seq_1", pc, 32'h4);
    tick(); check("seq_2", pc, 32'h8);
    tick(); check("seq_3", pc, 32'hC);

    // Asynchronous reset mid-run, checked away from any edge.
    @(negedge clk);
    rst = 1;
    #1;
    check("async_reset_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    jump(32'h10);
    check("redirect_0x10", pc, 32'h10);
    stall = 1;
    tick(); check("stall_hold", pc, 32'h10);
    redirect_valid = 1; redirect_target = 32'h80;
    #1; check("pc_next_redirect_in_stall", pc_next, 32'h80);
    tick(); check("redirect_over_stall", pc, 32'h80);
    idle_inputs();

    trap_valid = 1; trap_vector = 32'h100;
    redirect_valid = 1; redirect_target = 32'h200;
    tick(); check("trap_over_redirect", pc, 32'h100);
    check("trap_aligned_no_err", {31'b0, misalign_err}, 32'h0);
    idle_inputs();
    jump(32'h203);
    check("misaligned_redirect_pc", pc, 32'h200);
    check("misaligned_redirect_err", {31'b0, misalign_err}, 32'h1);
    tick();
    check("misalign_one_cycle", {31'b0, misalign_err}, 32'h0);
    check("after_misalign_seq", pc, 32'h204);
    trap_valid = 1; trap_vector = 32'h302;
    tick(); trap_valid = 0;
    check("misaligned_trap_pc", pc, 32'h300);
    check("misaligned_trap_err", {31'b0, misalign_err}, 32'h1);

    jump(32'hFFFF_FFFC);
    check("near_wrap", pc, 32'hFFFF_FFFC);
    tick(); check("wrap_to_zero", pc, 32'h0);

`ifdef PC_RAS_EN
    jump(32'h40);
    call_valid = 1; tick(); call_valid = 0;
    check("call_seq_pc", pc, 32'h44);
    check("call_count", {29'b0, ras_count}, 32'h1);
    jump(32'h400);
    check("redirect_keeps_ras", {29'b0, ras_count}, 32'h1);
    ret_valid = 1;
    #1; check("ret_pc_next", pc_next, 32'h44);
    tick(); ret_valid = 0;
    check("ret_pc", pc, 32'h44);
    check("ret_count", {29'b0, ras_count}, 32'h0);
    jump(32'h400);
    ret_valid = 1; tick(); ret_valid = 0;
    check("ret_empty_seq", pc, 32'h404);

    for (int i = 0; i < 5; i++) begin
      jump(32'(i * 16));
      call_valid = 1; tick(); call_valid = 0;
    end
    check("five_calls_count", {29'b0, ras_count}, 32'h4);
    stall = 1; call_valid = 1; tick(); call_valid = 0; stall = 0;
    check("stalled_call_ignored", {29'b0, ras_count}, 32'h4);
    ret_valid = 1;
    tick(); check("ret_1", pc, 32'h44);
    tick(); check("ret_2", pc, 32'h34);
    tick(); check("ret_3", pc, 32'h24);
    tick(); check("ret_4", pc, 32'h14);
    check("rets_drained", {29'b0, ras_count}, 32'h0);
    tick(); check("ret_5_seq", pc, 32'h18);
    ret_valid = 0;

    jump(32'h500);
    call_valid = 1; tick();
    tick();
    ret_valid = 1;
    #1; check("call_ret_pc_next", pc_next, 32'h508);
    tick(); call_valid = 0; ret_valid = 0;
    check("call_ret_pc", pc, 32'h508);
    check("call_ret_count", {29'b0, ras_count}, 32'h2);
    ret_valid = 1; tick(); ret_valid = 0;
    check("replaced_top", pc, 32'h50C);
    call_valid = 1; tick(); tick(); call_valid = 0;
    check("count_3", {29'b0, ras_count}, 32'h3);
    trap_valid = 1; trap_vector = 32'h600;
    tick(); trap_valid = 0;
    check("trap_pc", pc, 32'h600);
    check("trap_clears_ras", {29'b0, ras_count}, 32'h0);
`else
    jump(32'h40);
    call_valid = 1; tick(); call_valid = 0;
    check("no_ras_call_seq", pc, 32'h44);
    check("no_ras_count", {29'b0, ras_count}, 32'h0);
    ret_valid = 1; tick(); ret_valid = 0;
    check("no_ras_ret_seq", pc, 32'h48);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout pc=%h expected=finish", pc);
    $fatal(1, "timeout");
  end

endmodule
